// File: rtl/pipe_operand_loader.sv
// rtl/pipe_operand_loader.sv - assembles serial words into A..D bundles and tracks pipeline latency
module pipe_operand_loader #(
  parameter int N     = 10,
  parameter int LAT   = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic [N-1:0]     A,
  output logic [N-1:0]     B,
  output logic [N-1:0]     C,
  output logic [N-1:0]     D,
  output logic             op_valid,
  output logic             res_valid,
  output logic [CNT_W-1:0] bundle_cnt
);

  localparam logic [1:0] S_A = 2'd0;
  localparam logic [1:0] S_B = 2'd1;
  localparam logic [1:0] S_C = 2'd2;
  localparam logic [1:0] S_D = 2'd3;

  logic [1:0]     state;
  logic [N-1:0]   sa;
  logic [N-1:0]   sb;
  logic [N-1:0]   sc;
  logic [LAT-1:0] lat_sr;
  logic           xfer;

  assign in_ready = rst_n & ~abort;
  assign xfer     = in_valid & in_ready;

  // A..D are only written on the D-word transfer, so partial loads never disturb them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_A;
      sa         <= '0;
      sb         <= '0;
      sc         <= '0;
      A          <= '0;
      B          <= '0;
      C          <= '0;
      D          <= '0;
      op_valid   <= 1'b0;
      bundle_cnt <= '0;
    end else begin
      op_valid <= 1'b0;
      if (abort) begin
        state <= S_A;
      end else if (xfer) begin
        case (state)
          S_A: begin
            sa    <= in_data;
            state <= S_B;
          end
          S_B: begin
            sb    <= in_data;
            state <= S_C;
          end
          S_C: begin
            sc    <= in_data;
            state <= S_D;
          end
          default: begin
            A          <= sa;
            B          <= sb;
            C          <= sc;
            D          <= in_data;
            op_valid   <= 1'b1;
            bundle_cnt <= bundle_cnt + CNT_W'(1);
            state      <= S_A;
          end
        endcase
      end
    end
  end

  // One bit per issued bundle in flight, so overlapping results stay separate pulses
  generate
    if (LAT == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lat_sr <= '0;
        else        lat_sr <= op_valid;
      end
    end else begin : g_latn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lat_sr <= '0;
        else        lat_sr <= {lat_sr[LAT-2:0], op_valid};
      end
    end
  endgenerate

  assign res_valid = lat_sr[LAT-1];

endmodule

// File: tb/tb_pipe_operand_loader.sv
// tb/tb_pipe_operand_loader.sv - randomized self-checking bench for pipe_operand_loader
module tb_pipe_operand_loader;
  localparam int N     = 10;
  localparam int LAT   = 3;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             abort = 1'b0;
  logic [N-1:0]     A, B, C, D;
  logic             op_valid, res_valid;
  logic [CNT_W-1:0] bundle_cnt;

  always #5 clk = ~clk;

  pipe_operand_loader #(.N(N), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .A(A), .B(B), .C(C), .D(D),
    .op_valid(op_valid), .res_valid(res_valid), .bundle_cnt(bundle_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: words collected since the last issue/abort, and op_valid history
  logic [N-1:0]     words[$];
  logic [N-1:0]     m_a, m_b, m_c, m_d;
  logic             m_ov, m_rv;
  logic [CNT_W-1:0] m_cnt;
  logic             ov_hist[$];

  task automatic model_reset();
    words.delete();
    ov_hist.delete();
    m_a = '0; m_b = '0; m_c = '0; m_d = '0;
    m_ov = 1'b0; m_rv = 1'b0; m_cnt = '0;
    for (int i = 0; i < LAT; i++) ov_hist.push_back(1'b0);
  endtask

  task automatic drive_cycle(input logic v, input logic [N-1:0] d, input logic ab);
    in_valid = v; in_data = d; abort = ab;
    @(posedge clk);
    m_rv = ov_hist.pop_front();
    m_ov = 1'b0;
    if (ab) begin
      words.delete();
    end else if (v) begin
      words.push_back(d);
      if (words.size() == 4) begin
        m_a = words[0]; m_b = words[1]; m_c = words[2]; m_d = words[3];
        m_ov = 1'b1;
        m_cnt = m_cnt + 1'b1;
        words.delete();
      end
    end
    ov_hist.push_back(m_ov);
    #1;
  endtask

  function automatic string dut_str();
    return $sformatf("A=%0d B=%0d C=%0d D=%0d ov=%0b rv=%0b cnt=%0d", A, B, C, D, op_valid, res_valid, bundle_cnt);
  endfunction

  function automatic string mdl_str();
    return $sformatf("A=%0d B=%0d C=%0d D=%0d ov=%0b rv=%0b cnt=%0d", m_a, m_b, m_c, m_d, m_ov, m_rv, m_cnt);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({A, B, C, D, op_valid, res_valid, bundle_cnt, in_ready} !== '0)
      $display("FAIL reset_outputs: got %s rdy=%0b, required all zero", dut_str(), in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b, required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_single();
    logic [N-1:0] w[4] = '{10, 12, 6, 3};
    int rv_at = -1;
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, w[i], 1'b0);
    n_checks++;
    if ({A, B, C, D, op_valid, bundle_cnt} !== {10'd10, 10'd12, 10'd6, 10'd3, 1'b1, 8'd1})
      $display("FAIL single_issue: got %s, required A=10 B=12 C=6 D=3 ov=1 cnt=1", dut_str());
    else n_pass++;
    for (int t = 1; t <= LAT + 2; t++) begin
      drive_cycle(1'b0, '0, 1'b0);
      if (res_valid === 1'b1) rv_at = t;
      n_checks++;
      if ({A, B, C, D, op_valid, res_valid, bundle_cnt} !== {m_a, m_b, m_c, m_d, m_ov, m_rv, m_cnt})
        $display("FAIL single_cycle%0d: got %s, required %s", t, dut_str(), mdl_str());
      else n_pass++;
    end
    n_checks++;
    if (rv_at != LAT) $display("FAIL single_res_delay: got %0d, required %0d", rv_at, LAT);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] w[8] = '{10, 10, 5, 3, 20, 11, 1, 4};
    for (int i = 0; i < 8 + LAT + 3; i++) begin
      if (i < 8) drive_cycle(1'b1, w[i], 1'b0);
      else       drive_cycle(1'b0, '0, 1'b0);
      n_checks++;
      if ({A, B, C, D, op_valid, res_valid, bundle_cnt} !== {m_a, m_b, m_c, m_d, m_ov, m_rv, m_cnt})
        $display("FAIL b2b_cycle%0d: got %s, required %s", i, dut_str(), mdl_str());
      else n_pass++;
    end
    n_checks++;
    if ({A, B, C, D, bundle_cnt} !== {10'd20, 10'd11, 10'd1, 10'd4, 8'd3})
      $display("FAIL b2b_final: got %s, required A=20 B=11 C=1 D=4 cnt=3", dut_str());
    else n_pass++;
  endtask

  task automatic test_gaps();
    logic [N-1:0] w[4] = '{7, 8, 9, 1};
    logic [N-1:0] dx;
    dx = 'x;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive_cycle(1'b1, w[i/2], 1'b0);
      else            drive_cycle(1'b0, dx, 1'b0);
      n_checks++;
      if ({A, B, C, D, op_valid, res_valid, bundle_cnt} !== {m_a, m_b, m_c, m_d, m_ov, m_rv, m_cnt})
        $display("FAIL gaps_cycle%0d: got %s, required %s", i, dut_str(), mdl_str());
      else n_pass++;
    end
    drive_cycle(1'b0, dx, 1'b0);
    n_checks++;
    if ({A, B, C, D, op_valid} !== {10'd7, 10'd8, 10'd9, 10'd1, 1'b0})
      $display("FAIL gaps_hold: got %s, required A=7 B=8 C=9 D=1 ov=0", dut_str());
    else n_pass++;
  endtask

  task automatic test_abort();
    drive_cycle(1'b1, 10'd1, 1'b0);
    drive_cycle(1'b1, 10'd2, 1'b0);
    in_valid = 1'b1; in_data = 10'd99; abort = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL abort_ready: got %0b, required 0", in_ready);
    else n_pass++;
    drive_cycle(1'b1, 10'd99, 1'b1);
    for (int i = 5; i <= 8; i++) begin
      drive_cycle(1'b1, N'(i), 1'b0);
      n_checks++;
      if ({A, B, C, D, op_valid, res_valid, bundle_cnt} !== {m_a, m_b, m_c, m_d, m_ov, m_rv, m_cnt})
        $display("FAIL abort_word%0d: got %s, required %s", i, dut_str(), mdl_str());
      else n_pass++;
    end
    n_checks++;
    if ({A, B, C, D, op_valid} !== {10'd5, 10'd6, 10'd7, 10'd8, 1'b1})
      $display("FAIL abort_issue: got %s, required A=5 B=6 C=7 D=8 ov=1", dut_str());
    else n_pass++;
  endtask

  task automatic test_reset_in_flight();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, N'($urandom_range(1, 1023)), 1'b0);
    drive_cycle(1'b0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({A, B, C, D, op_valid, res_valid, bundle_cnt, in_ready} !== '0)
      $display("FAIL async_reset: got %s rdy=%0b, required all zero", dut_str(), in_ready);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 6; i++) begin
      if (i < LAT + 2) drive_cycle(1'b0, '0, 1'b0);
      else             drive_cycle(1'b1, N'(i * 37), 1'b0);
      n_checks++;
      if ({A, B, C, D, op_valid, res_valid, bundle_cnt} !== {m_a, m_b, m_c, m_d, m_ov, m_rv, m_cnt})
        $display("FAIL post_reset_cycle%0d: got %s, required %s", i, dut_str(), mdl_str());
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    for (int b = 1; b <= 256; b++) begin
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, N'($urandom), 1'b0);
      if (b == 255) begin
        n_checks++;
        if (bundle_cnt !== 8'd255) $display("FAIL wrap_255: got %0d, required 255", bundle_cnt);
        else n_pass++;
      end
    end
    n_checks++;
    if (bundle_cnt !== 8'd0) $display("FAIL wrap_256: got %0d, required 0", bundle_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, N'($urandom), $urandom_range(0, 15) == 0);
      n_checks++;
      if ({A, B, C, D, op_valid, res_valid, bundle_cnt} !== {m_a, m_b, m_c, m_d, m_ov, m_rv, m_cnt})
        $display("FAIL random_cycle%0d: got %s, required %s", i, dut_str(), mdl_str());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gaps();
    test_abort();
    test_reset_in_flight();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
